// File: rtl/dmem_copy_engine.sv
// Word-granular block-copy engine: second master on the data memory port,
// one asynchronous read then one synchronous write per word, ascending addresses.
module dmem_copy_engine #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout,
  output logic                 mem_read,
  output logic                 mem_write
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] WORD_BYTES = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        src_q, src_d;
  logic [AW-1:0]        dst_q, dst_d;
  logic [AW-1:0]        buf_q, buf_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] words_q, words_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      words_q <= words_d;
    end
  end

  // Next-state: command inputs are only looked at while idle.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    words_d = words_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            state_d = S_ERR;
            words_d = '0;
          end else if (len == '0) begin
            state_d = S_DONE;
            words_d = '0;
          end else begin
            state_d = S_READ;
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            words_d = '0;
          end
        end
      end
      S_READ: begin
        buf_d   = mem_dout;
        src_d   = src_q + WORD_BYTES;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dst_d   = dst_q + WORD_BYTES;
        words_d = words_q + LEN_WIDTH'(1);
        rem_d   = rem_q - LEN_WIDTH'(1);
        state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only.
  assign busy       = (state_q == S_READ) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign words_done = words_q;
  assign mem_read   = (state_q == S_READ);
  assign mem_write  = (state_q == S_WRITE);
  assign mem_addr   = (state_q == S_READ)  ? src_q :
                      (state_q == S_WRITE) ? dst_q : '0;
  assign mem_din    = (state_q == S_WRITE) ? buf_q : '0;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine: table of copy commands plus
// hand-written overlap, ignored-start and reset-mid-copy sequences.
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, err, mem_read, mem_write;
  logic [15:0] words_done;
  logic [31:0] mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  dmem_copy_engine #(.LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  // 4 KB memory model, word index = addr[11:2]; initial contents 0x1000+index.
  logic [31:0] mem [1024];
  logic        init_req, pk_we;
  logic [9:0]  pk_idx;
  logic [31:0] pk_data;
  int n_busy, n_rd, n_wr, n_done;

  assign mem_dout = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000 + 32'(i);
    end else if (pk_we) begin
      mem[pk_idx] <= pk_data;
    end else if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_din;
    end
    if (busy)      n_busy <= n_busy + 1;
    if (mem_read)  n_rd   <= n_rd + 1;
    if (mem_write) n_wr   <= n_wr + 1;
    if (done)      n_done <= n_done + 1;
  end

  int tests, fails;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_init();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] d);
    pk_we = 1'b1; pk_idx = idx; pk_data = d;
    tick();
    pk_we = 1'b0;
  endtask

  function automatic logic [31:0] outs_or();
    return 32'(|{busy, done, err, words_done, mem_addr, mem_din, mem_read, mem_write});
  endfunction

  // Issue a command, follow it until done/err (bounded), check the address stream.
  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         output int ev, output bit got_err, output int bad_addr);
    logic [31:0] exp_a;
    int k;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    tick();
    start = 1'b0;
    ev = 0; got_err = 1'b0; bad_addr = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (busy) begin
        k = (cyc - 1) / 2;
        exp_a = (cyc % 2 == 1) ? 32'(s + 32'(4 * k)) : 32'(d + 32'(4 * k));
        if (mem_addr !== exp_a) bad_addr++;
      end
      if (done || err) begin
        ev = cyc; got_err = err;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          exp_cyc;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ev, bad, b0, r0, w0, d0, nbad;
    bit gerr;
    int exp_len;
    logic [9:0] di, si;

    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd4, 9,  1'b0};
    vecs[1] = '{32'h0000_0100, 32'h0000_0200, 16'd0, 1,  1'b0};
    vecs[2] = '{32'h0000_0102, 32'h0000_0200, 16'd4, 1,  1'b1};
    vecs[3] = '{32'h0000_0100, 32'h0000_0201, 16'd3, 1,  1'b1};
    vecs[4] = '{32'h0000_0300, 32'h0000_0400, 16'd1, 3,  1'b0};
    vecs[5] = '{32'h0000_0040, 32'h0000_0800, 16'd7, 15, 1'b0};
    vecs[6] = '{32'hFFFF_FFF8, 32'h0000_0600, 16'd3, 7,  1'b0};

    tests = 0; fails = 0;
    n_busy = 0; n_rd = 0; n_wr = 0; n_done = 0;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    init_req = 1'b1; pk_we = 1'b0; pk_idx = '0; pk_data = '0;
    tick();
    init_req = 1'b0;
    tick();
    check("reset_outs_held", outs_or(), 32'd0);
    reset = 1'b0;
    tick();
    check("reset_outs", outs_or(), 32'd0);
    r0 = n_rd; w0 = n_wr;
    for (int i = 0; i < 10; i++) tick();
    check("idle_no_access", 32'((n_rd - r0) + (n_wr - w0)), 32'd0);

    foreach (vecs[v]) begin
      mem_init();
      b0 = n_busy; r0 = n_rd; w0 = n_wr;
      run_cmd(vecs[v].src, vecs[v].dst, vecs[v].len, ev, gerr, bad);
      exp_len = vecs[v].exp_err ? 0 : int'(vecs[v].len);
      check($sformatf("v%0d_event_cycle", v), 32'(ev), 32'(vecs[v].exp_cyc));
      check($sformatf("v%0d_err", v), 32'(gerr), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_busy_cycles", v), 32'(n_busy - b0), 32'(2 * exp_len));
      check($sformatf("v%0d_reads", v), 32'(n_rd - r0), 32'(exp_len));
      check($sformatf("v%0d_writes", v), 32'(n_wr - w0), 32'(exp_len));
      check($sformatf("v%0d_words_done", v), 32'(words_done), 32'(exp_len));
      check($sformatf("v%0d_addr_seq", v), 32'(bad), 32'd0);
      nbad = 0;
      for (int k = 0; k < exp_len; k++) begin
        di = 10'((vecs[v].dst >> 2) + 32'(k));
        si = 10'((vecs[v].src >> 2) + 32'(k));
        if (mem[di] !== 32'h1000 + 32'(si)) nbad++;
      end
      check($sformatf("v%0d_dst_data", v), 32'(nbad), 32'd0);
      tick();
      check($sformatf("v%0d_pulse_one_cycle", v), 32'({done, err, busy}), 32'd0);
    end

    // Overlapping ranges: first source word propagates forward.
    mem_init();
    poke(10'h040, 32'hA); poke(10'h041, 32'hB); poke(10'h042, 32'hC);
    run_cmd(32'h100, 32'h104, 16'd2, ev, gerr, bad);
    check("ovl_event_cycle", 32'(ev), 32'd5);
    check("ovl_mem_104", mem[10'h041], 32'hA);
    check("ovl_mem_108", mem[10'h042], 32'hA);
    check("ovl_mem_100", mem[10'h040], 32'hA);

    // Start pulses during an active copy and during DONE are ignored.
    mem_init();
    src_addr = 32'h100; dst_addr = 32'h200; len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0; ev = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin ev = cyc; break; end
      start = (cyc == 3);
      if (cyc == 3) begin src_addr = 32'h500; dst_addr = 32'h600; len = 16'd2; end
      tick();
    end
    check("ign_event_cycle", 32'(ev), 32'd9);
    check("ign_words_done", 32'(words_done), 32'd4);
    check("ign_dst_w3", mem[10'h083], 32'h1043);
    src_addr = 32'h500; dst_addr = 32'h600; len = 16'd1; start = 1'b1;
    tick();
    check("ign_done_start_idle", 32'({busy, done}), 32'd0);
    src_addr = 32'h300; dst_addr = 32'h700;
    tick();
    start = 1'b0;
    check("acc_read_addr", mem_addr, 32'h300);
    check("acc_read", 32'({busy, mem_read}), 32'b11);
    tick();
    check("acc_write_addr", mem_addr, 32'h700);
    check("acc_write_data", mem_din, 32'h10C0);
    tick();
    check("acc_done", 32'({done, words_done}), {15'd0, 1'b1, 16'd1});
    check("ign_no_600_write", mem[10'h180], 32'h1180);

    // Reset during the WRITE of the second word.
    mem_init();
    w0 = n_wr; d0 = n_done;
    src_addr = 32'h100; dst_addr = 32'h200; len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("rmid_in_write", 32'({mem_write, mem_addr}), {31'd1, 1'b0, 32'h204} >> 0 & 33'h1_FFFF_FFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_outs", outs_or(), 32'd0);
    r0 = n_rd;
    for (int i = 0; i < 10; i++) tick();
    check("rmid_no_more_access", 32'(n_rd - r0), 32'd0);
    check("rmid_writes", 32'(n_wr - w0), 32'd2);
    check("rmid_no_done", 32'(n_done - d0), 32'd0);
    check("rmid_dst0", mem[10'h080], 32'h1040);
    check("rmid_dst1", mem[10'h081], 32'h1041);
    check("rmid_dst2_untouched", mem[10'h082], 32'h1082);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
